combo_lock_param: RTL and testbench

Parametrised multi-digit combination lock FSM, successor to the fixed six-digit lab lock. It accepts one digit per `digit_valid` strobe and tracks a correct path and an error path. After `CODE_LEN` digits it shows OPEN or CLOSED. It adds a run-time reprogrammable code, a synchronous clear, and an optional failed-attempt lockout. It sits between the switch/key front end and the HEX display driver in the lab top level.

---
 rtl/combo_lock_pkg.sv | 33 +++
 rtl/seg7_decode.sv | 16 +
 rtl/combo_lock_param.sv | 204 ++++++++++++++++++++
 tb/tb_combo_lock_param.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/combo_lock_pkg.sv
// Shared types and 7-segment constants for the parametrised combination lock.
// Segments are active-low, bit order {a,b,c,d,e,f,g}.
package combo_lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OK,
        ST_ERR,
        ST_OPEN,
        ST_CLOSED,
        ST_PROG,
        ST_LOCKOUT
    } state_t;

    localparam logic [6:0] SEG_ZERO   = 7'b0000001;
    localparam logic [6:0] SEG_OPEN   = 7'b1100010;  // 'o'
    localparam logic [6:0] SEG_CLOSED = 7'b0110001;  // 'C'
    localparam logic [6:0] SEG_ERR    = 7'b1111010;  // 'r'
    localparam logic [6:0] SEG_LOCK   = 7'b1110001;  // 'L'

    // Index 15 first: F E d C b A 9 8 7 6 5 4 3 2 1 0
    localparam logic [15:0][6:0] SEG_DIGITS = {
        7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
        7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        return SEG_DIGITS[v];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit to active-low 7-segment decode with out-of-base flag.
// Latency 0; no flow control.
module seg7_decode
    import combo_lock_pkg::*;
#(
    parameter int BASE = 10
) (
    input  logic [3:0] val,
    output logic [6:0] seg,
    output logic       invalid
);

    assign seg     = seg_of(val);
    assign invalid = ({1'b0, val} >= 5'(BASE));

endmodule

// File: rtl/combo_lock_param.sv
// Parametrised combination lock FSM with reprogrammable code; optional lockout via COMBO_LOCK_LOCKOUT_EN.
// Latency: 1 clock from digit_valid to state/outputs. No backpressure: every strobe is consumed or ignored.
module combo_lock_param
    import combo_lock_pkg::*;
#(
    parameter int                      CODE_LEN       = 6,
    parameter int                      BASE           = 10,
    parameter logic [4*CODE_LEN-1:0]   DEFAULT_CODE   = 24'h211525,
    parameter int                      MAX_FAILS      = 3,
    parameter int                      LOCKOUT_CYCLES = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [3:0]                      digit,
    input  logic                            digit_valid,
    input  logic                            clear,
    input  logic                            prog_req,
    output logic [6:0]                      hex0,
    output logic [$clog2(CODE_LEN+1)-1:0]   pos_o,
    output logic                            open_o,
    output logic                            closed_o,
    output logic                            lockout_o,
    output logic                            prog_o
);

    localparam int PW = $clog2(CODE_LEN + 1);
    localparam int CW = 4 * CODE_LEN;

    state_t           state, state_n;
    logic [PW-1:0]    pos_n;
    logic [6:0]       hex_n;
    logic [CW-1:0]    code, code_n;
    logic [CW-1:0]    shadow, shadow_n;
    logic [CW-1:0]    code_shift;
    logic [3:0]       code_dig;
    logic [6:0]       dig_seg;
    logic             dig_bad;
    logic             last_dig;
    logic             good;

`ifdef COMBO_LOCK_LOCKOUT_EN
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    logic [FW-1:0] fail_cnt, fail_n;
    logic [LW-1:0] lock_cnt, lock_n;
`endif

    seg7_decode #(.BASE(BASE)) u_dec (
        .val     (digit),
        .seg     (dig_seg),
        .invalid (dig_bad)
    );

    // Digit pos of the stored code sits in the top nibble after shifting left by pos nibbles.
    assign code_shift = code << {pos_o, 2'b00};
    assign code_dig   = code_shift[CW-1 -: 4];
    assign last_dig   = (pos_o == PW'(CODE_LEN - 1));
    assign good       = (state != ST_ERR) && !dig_bad && (digit == code_dig);

    always_comb begin
        state_n  = state;
        pos_n    = pos_o;
        hex_n    = hex0;
        code_n   = code;
        shadow_n = shadow;
`ifdef COMBO_LOCK_LOCKOUT_EN
        fail_n   = fail_cnt;
        lock_n   = lock_cnt;
`endif
        case (state)
            ST_IDLE, ST_OK, ST_ERR: begin
                if (clear) begin
                    state_n = ST_IDLE;
                    pos_n   = '0;
                    hex_n   = SEG_ZERO;
                end else if (digit_valid) begin
                    pos_n = pos_o + PW'(1);
                    hex_n = dig_bad ? SEG_ERR : dig_seg;
                    if (!last_dig) begin
                        state_n = good ? ST_OK : ST_ERR;
                    end else if (good) begin
                        state_n = ST_OPEN;
                        hex_n   = SEG_OPEN;
`ifdef COMBO_LOCK_LOCKOUT_EN
                        fail_n  = '0;
`endif
                    end else begin
`ifdef COMBO_LOCK_LOCKOUT_EN
                        if (fail_cnt == FW'(MAX_FAILS - 1)) begin
                            state_n = ST_LOCKOUT;
                            hex_n   = SEG_LOCK;
                            lock_n  = LW'(LOCKOUT_CYCLES - 1);
                        end else begin
                            state_n = ST_CLOSED;
                            hex_n   = SEG_CLOSED;
                            fail_n  = fail_cnt + FW'(1);
                        end
`else
                        state_n = ST_CLOSED;
                        hex_n   = SEG_CLOSED;
`endif
                    end
                end
            end
            ST_OPEN: begin
                if (clear) begin
                    state_n = ST_IDLE;
                    pos_n   = '0;
                    hex_n   = SEG_ZERO;
                end else if (prog_req) begin
                    state_n  = ST_PROG;
                    pos_n    = '0;
                    shadow_n = '0;
                end
            end
            ST_CLOSED: begin
                if (clear) begin
                    state_n = ST_IDLE;
                    pos_n   = '0;
                    hex_n   = SEG_ZERO;
                end
            end
            ST_PROG: begin
                if (clear) begin
                    state_n = ST_IDLE;
                    pos_n   = '0;
                    hex_n   = SEG_ZERO;
                end else if (digit_valid) begin
                    if (dig_bad) begin
                        state_n = ST_IDLE;
                        pos_n   = '0;
                        hex_n   = SEG_ERR;
                    end else begin
                        shadow_n = {shadow[CW-5:0], digit};
                        hex_n    = dig_seg;
                        if (last_dig) begin
                            code_n  = {shadow[CW-5:0], digit};
                            state_n = ST_IDLE;
                            pos_n   = '0;
                        end else begin
                            pos_n = pos_o + PW'(1);
                        end
                    end
                end
            end
`ifdef COMBO_LOCK_LOCKOUT_EN
            ST_LOCKOUT: begin
                if (lock_cnt == '0) begin
                    state_n = ST_IDLE;
                    pos_n   = '0;
                    hex_n   = SEG_ZERO;
                    fail_n  = '0;
                end else begin
                    lock_n = lock_cnt - LW'(1);
                end
            end
`endif
            default: begin
                state_n = ST_IDLE;
                pos_n   = '0;
                hex_n   = SEG_ZERO;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            pos_o    <= '0;
            hex0     <= SEG_ZERO;
            code     <= DEFAULT_CODE;
            shadow   <= '0;
            open_o   <= 1'b0;
            closed_o <= 1'b0;
            prog_o   <= 1'b0;
        end else begin
            state    <= state_n;
            pos_o    <= pos_n;
            hex0     <= hex_n;
            code     <= code_n;
            shadow   <= shadow_n;
            open_o   <= (state_n == ST_OPEN);
            closed_o <= (state_n == ST_CLOSED);
            prog_o   <= (state_n == ST_PROG);
        end
    end

`ifdef COMBO_LOCK_LOCKOUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fail_cnt  <= '0;
            lock_cnt  <= '0;
            lockout_o <= 1'b0;
        end else begin
            fail_cnt  <= fail_n;
            lock_cnt  <= lock_n;
            lockout_o <= (state_n == ST_LOCKOUT);
        end
    end
`else
    assign lockout_o = 1'b0;
`endif

endmodule

// File: tb/tb_combo_lock_param.sv
// Directed self-checking bench for combo_lock_param (default parameters).
// Covers both builds of COMBO_LOCK_LOCKOUT_EN.
module tb_combo_lock_param;

    localparam logic [6:0] E_ZERO   = 7'b0000001;
    localparam logic [6:0] E_ONE    = 7'b1001111;
    localparam logic [6:0] E_TWO    = 7'b0010010;
    localparam logic [6:0] E_FOUR   = 7'b1001100;
    localparam logic [6:0] E_OPEN   = 7'b1100010;
    localparam logic [6:0] E_CLOSED = 7'b0110001;
    localparam logic [6:0] E_ERR    = 7'b1111010;
    localparam logic [6:0] E_LOCK   = 7'b1110001;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] digit = '0;
    logic       digit_valid = 1'b0;
    logic       clear = 1'b0;
    logic       prog_req = 1'b0;
    logic [6:0] hex0;
    logic [2:0] pos_o;
    logic       open_o, closed_o, lockout_o, prog_o;

    int n_checks = 0;
    int n_fails  = 0;

    combo_lock_param dut (
        .clock       (clk),
        .reset       (reset),
        .digit       (digit),
        .digit_valid (digit_valid),
        .clear       (clear),
        .prog_req    (prog_req),
        .hex0        (hex0),
        .pos_o       (pos_o),
        .open_o      (open_o),
        .closed_o    (closed_o),
        .lockout_o   (lockout_o),
        .prog_o      (prog_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] d, input logic v, input logic c, input logic p);
        @(negedge clk);
        digit = d; digit_valid = v; clear = c; prog_req = p;
        @(posedge clk);
        #1;
        digit_valid = 1'b0; clear = 1'b0; prog_req = 1'b0;
    endtask

    task automatic attempt(input logic [23:0] code, input string tag);
        for (int i = 0; i < 6; i++) begin
            cyc(code[23-4*i -: 4], 1'b1, 1'b0, 1'b0);
            chk({tag, "_pos"}, 32'(pos_o), 32'(i + 1));
        end
    endtask

    task automatic do_clear(input string tag);
        cyc(4'd0, 1'b0, 1'b1, 1'b0);
        chk({tag, "_clr_pos"}, 32'(pos_o), 0);
        chk({tag, "_clr_flags"}, {open_o, closed_o, prog_o}, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hex", 32'(hex0), 32'(E_ZERO));
        chk("rst_pos", 32'(pos_o), 0);
        chk("rst_flags", {open_o, closed_o, lockout_o, prog_o}, 0);
        @(negedge clk);
        reset = 1'b1;

        // Correct default code with per-digit display checks
        cyc(4'd2, 1'b1, 1'b0, 1'b0);
        chk("open_d1_pos", 32'(pos_o), 1);
        chk("open_d1_hex", 32'(hex0), 32'(E_TWO));
        cyc(4'd1, 1'b1, 1'b0, 1'b0);
        chk("open_d2_pos", 32'(pos_o), 2);
        chk("open_d2_hex", 32'(hex0), 32'(E_ONE));
        cyc(4'd1, 1'b1, 1'b0, 1'b0);
        chk("open_d3_pos", 32'(pos_o), 3);
        cyc(4'd5, 1'b1, 1'b0, 1'b0);
        chk("open_d4_pos", 32'(pos_o), 4);
        cyc(4'd2, 1'b1, 1'b0, 1'b0);
        chk("open_d5_pos", 32'(pos_o), 5);
        chk("open_d5_flag", 32'(open_o), 0);
        cyc(4'd5, 1'b1, 1'b0, 1'b0);
        chk("open_d6_pos", 32'(pos_o), 6);
        chk("open_flags", {open_o, closed_o}, 32'b10);
        chk("open_hex", 32'(hex0), 32'(E_OPEN));

        // OPEN is sticky against further digits
        cyc(4'd0, 1'b1, 1'b0, 1'b0);
        chk("sticky_open", 32'(open_o), 1);
        chk("sticky_pos", 32'(pos_o), 6);
        chk("sticky_hex", 32'(hex0), 32'(E_OPEN));
        do_clear("c1");

        // Wrong digit from the third position
        attempt(24'h210020, "bad1");
        chk("bad1_flags", {open_o, closed_o}, 32'b01);
        chk("bad1_hex", 32'(hex0), 32'(E_CLOSED));
        do_clear("c2");

        // Invalid digit mid-attempt, remaining digits correct still fails
        cyc(4'd2, 1'b1, 1'b0, 1'b0);
        cyc(4'd12, 1'b1, 1'b0, 1'b0);
        chk("inv_hex", 32'(hex0), 32'(E_ERR));
        chk("inv_pos", 32'(pos_o), 2);
        cyc(4'd1, 1'b1, 1'b0, 1'b0);
        chk("inv_after_hex", 32'(hex0), 32'(E_ONE));
        chk("inv_after_pos", 32'(pos_o), 3);
        cyc(4'd5, 1'b1, 1'b0, 1'b0);
        cyc(4'd2, 1'b1, 1'b0, 1'b0);
        cyc(4'd5, 1'b1, 1'b0, 1'b0);
        chk("inv_closed", {open_o, closed_o}, 32'b01);
        do_clear("c3");

        // Open, then reprogram to 987654
        attempt(24'h211525, "open2");
        chk("open2_flag", 32'(open_o), 1);
        cyc(4'd0, 1'b0, 1'b0, 1'b1);
        chk("prog_enter", {prog_o, open_o}, 32'b10);
        chk("prog_enter_pos", 32'(pos_o), 0);
        for (int i = 0; i < 5; i++) begin
            cyc(4'(9 - i), 1'b1, 1'b0, 1'b0);
            chk("prog_pos", 32'(pos_o), 32'(i + 1));
            chk("prog_flag", 32'(prog_o), 1);
        end
        cyc(4'd4, 1'b1, 1'b0, 1'b0);
        chk("prog_done_flag", 32'(prog_o), 0);
        chk("prog_done_pos", 32'(pos_o), 0);
        chk("prog_done_hex", 32'(hex0), 32'(E_FOUR));
        do_clear("c4");
        attempt(24'h987654, "newcode");
        chk("newcode_open", {open_o, closed_o}, 32'b10);
        do_clear("c5");
        attempt(24'h211525, "oldcode");
        chk("oldcode_closed", {open_o, closed_o}, 32'b01);
        do_clear("c6");

        // prog_req outside OPEN is ignored
        cyc(4'd0, 1'b0, 1'b0, 1'b1);
        chk("prog_ignored", 32'(prog_o), 0);

        // clear beats a same-cycle digit mid-attempt
        cyc(4'd9, 1'b1, 1'b0, 1'b0);
        cyc(4'd8, 1'b1, 1'b0, 1'b0);
        cyc(4'd7, 1'b1, 1'b1, 1'b0);
        chk("clr_vs_dig_pos", 32'(pos_o), 0);
        attempt(24'h987654, "restart");
        chk("restart_open", 32'(open_o), 1);

        // Reset during PROG restores the default code
        cyc(4'd0, 1'b0, 1'b0, 1'b1);
        cyc(4'd1, 1'b1, 1'b0, 1'b0);
        cyc(4'd2, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midrst_pos", 32'(pos_o), 0);
        chk("midrst_flags", {open_o, closed_o, lockout_o, prog_o}, 0);
        chk("midrst_hex", 32'(hex0), 32'(E_ZERO));
        attempt(24'h211525, "defcode");
        chk("defcode_open", 32'(open_o), 1);
        do_clear("c7");

`ifdef COMBO_LOCK_LOCKOUT_EN
        attempt(24'h000000, "lk1");
        chk("lk1_closed", {closed_o, lockout_o}, 32'b10);
        do_clear("c8");
        attempt(24'h000000, "lk2");
        chk("lk2_closed", {closed_o, lockout_o}, 32'b10);
        do_clear("c9");
        attempt(24'h000000, "lk3");
        chk("lk3_lock", {closed_o, lockout_o}, 32'b01);
        chk("lk3_hex", 32'(hex0), 32'(E_LOCK));
        for (int i = 0; i < 15; i++) begin
            cyc(4'd2, 1'b1, 1'(i % 2), 1'b1);
            chk("lk_hold", 32'(lockout_o), 1);
            chk("lk_hold_pos", 32'(pos_o), 6);
        end
        cyc(4'd0, 1'b0, 1'b0, 1'b0);
        chk("lk_release", 32'(lockout_o), 0);
        chk("lk_release_pos", 32'(pos_o), 0);
        attempt(24'h211525, "lk_after");
        chk("lk_after_open", 32'(open_o), 1);
        do_clear("c10");
        attempt(24'h000000, "lk_cnt_clr");
        chk("lk_cnt_clr_closed", {closed_o, lockout_o}, 32'b10);
`else
        for (int k = 0; k < 3; k++) begin
            attempt(24'h000000, "nolk");
            chk("nolk_closed", {closed_o, lockout_o}, 32'b10);
            do_clear("nolk_c");
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
